// File: rtl/collision_lookup_arbiter.sv
// Shared wall-collision lookup server: round-robin arbitration of tile queries
// from the player and enemy movers, returning one registered wall-hit per grant.
`timescale 1ns/1ps
module collision_lookup_arbiter #(
    parameter int unsigned N_REQ = 6,
    parameter int unsigned MAP_W = 20,
    parameter int unsigned MAP_H = 15,
    parameter logic [0:MAP_W*MAP_H-1] MAP = {
        20'b1111_1111_1111_1111_1111,
        20'b1000_0000_0000_0000_0001,
        20'b1001_1000_0000_0110_0001,
        20'b1000_0000_1100_0000_0001,
        20'b1000_0000_0000_0000_0001,
        20'b1110_0011_1111_1100_0111,
        20'b1000_0000_0000_0000_0001,
        20'b1000_1000_0000_0001_0001,
        20'b1000_1000_0000_0001_0001,
        20'b1000_0000_0000_0000_0001,
        20'b1110_0011_1111_1100_0111,
        20'b1000_0000_0000_0000_0001,
        20'b1001_1000_0000_0110_0001,
        20'b1000_0000_0000_0000_0001,
        20'b1111_1111_1111_1111_1111
    }
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*5-1:0] qx,
    input  logic [N_REQ*4-1:0] qy,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic               rsp_hit,
    output logic               busy
);

    localparam int unsigned X_W   = 5;
    localparam int unsigned Y_W   = 4;
    localparam int unsigned IDX_W = 9;
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [X_W-1:0]   qx_lat, qx_lat_nxt;
    logic [Y_W-1:0]   qy_lat, qy_lat_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [N_REQ-1:0] rsp_valid_nxt;
    logic             rsp_hit_nxt;
    logic             busy_nxt;

    logic             found;
    logic [PTR_W-1:0] sel;
    logic [PTR_W-1:0] cand;
    logic             in_map;
    logic [IDX_W-1:0] idx;
    logic             wall;

    // Round-robin pick: first active request strictly after the last winner
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            cand = PTR_W'((32'(rr_ptr) + 32'(k)) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Wall lookup for the latched tile; anything off the map reads as wall
    always_comb begin
        in_map = (32'(qx_lat) < MAP_W) && (32'(qy_lat) < MAP_H);
        idx    = IDX_W'(qy_lat) * IDX_W'(MAP_W) + IDX_W'(qx_lat);
        wall   = in_map ? MAP[idx] : 1'b1;
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        qx_lat_nxt    = qx_lat;
        qy_lat_nxt    = qy_lat;
        gnt_nxt       = '0;
        rsp_valid_nxt = '0;
        rsp_hit_nxt   = rsp_hit;
        busy_nxt      = busy;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt[sel] = 1'b1;
                    rr_ptr_nxt   = sel;
                    qx_lat_nxt   = qx[int'(sel)*X_W +: X_W];
                    qy_lat_nxt   = qy[int'(sel)*Y_W +: Y_W];
                    busy_nxt     = 1'b1;
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                rsp_valid_nxt[rr_ptr] = 1'b1;
                rsp_hit_nxt           = wall;
                state_nxt             = RESP;
            end
            RESP: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= PTR_W'(N_REQ - 1);
            qx_lat    <= '0;
            qy_lat    <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_hit   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            qx_lat    <= qx_lat_nxt;
            qy_lat    <= qy_lat_nxt;
            gnt       <= gnt_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_hit   <= rsp_hit_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule
